// File: rtl/tree_adder_acc_ctrl.sv
// Sequencer for a pipelined tree adder: forwards accepted beats to the adder,
// sums the returned partial sums into one frame total and hands it downstream.
module tree_adder_acc_ctrl #(
    parameter  int IDW       = 10,
    parameter  int DATA_NUM  = 8,
    localparam int TA_ODW    = IDW + $clog2(DATA_NUM),
    parameter  int ACC_DW    = 24,
    parameter  int MAX_BEATS = 16,
    parameter  int PEND_DW   = 4,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_vld,
    output logic                    o_rdy,
    input  logic [DATA_NUM*IDW-1:0] i_data,
    input  logic                    i_last,
    output logic                    o_ta_vld,
    output logic [DATA_NUM*IDW-1:0] o_ta_data,
    input  logic                    i_ta_vld,
    input  logic [TA_ODW-1:0]       i_ta_reslt,
    output logic                    o_sum_vld,
    input  logic                    i_sum_rdy,
    output logic [ACC_DW-1:0]       o_sum,
    output logic [CNT_W-1:0]        o_beat_cnt,
    output logic                    o_ovf,
    output logic                    o_trunc,
    output logic                    o_err
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PEND_DW-1:0]  pending;
    logic [ACC_DW-1:0]   acc;
    logic [ACC_DW:0]     acc_add;
    logic [CNT_W-1:0]    beat_cnt;
    logic [ACC_DW-1:0]   sum_q;
    logic                ovf_flag;
    logic                trunc_flag;
    logic                err_q;
    logic                accept;
    logic                result_ok;
    logic                forced;
    logic                last_eff;
    logic                hold_release;
    logic                drain_done;

    assign accept       = i_vld & o_rdy;
    // A result with nothing in flight only counts if a beat is accepted the
    // same cycle, which is the zero-latency adder case.
    assign result_ok    = i_ta_vld & ((pending != '0) | accept);
    assign forced       = (beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign last_eff     = i_last | forced;
    assign hold_release = (state == HOLD) & i_sum_rdy;
    assign drain_done   = (state == DRAIN) & (pending == '0);
    assign acc_add      = {1'b0, acc} + {{(ACC_DW + 1 - TA_ODW){1'b0}}, i_ta_reslt};

    assign o_ta_vld     = accept;
    assign o_ta_data    = i_data;
    assign o_sum        = sum_q;
    assign o_beat_cnt   = beat_cnt;
    assign o_err        = err_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = last_eff ? DRAIN : ACCUM;
            ACCUM:   if (accept && last_eff) state_nxt = DRAIN;
            DRAIN:   if (pending == '0) state_nxt = HOLD;
            HOLD:    if (i_sum_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is held low during reset itself, not only once the state settles.
    always_comb begin
        o_rdy     = 1'b0;
        o_sum_vld = 1'b0;
        o_ovf     = 1'b0;
        o_trunc   = 1'b0;
        case (state)
            IDLE, ACCUM: o_rdy = ~i_rst;
            HOLD: begin
                o_sum_vld = 1'b1;
                o_ovf     = ovf_flag;
                o_trunc   = trunc_flag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending <= '0;
        end else begin
            case ({accept, result_ok})
                2'b10:   pending <= pending + PEND_DW'(1);
                2'b01:   pending <= pending - PEND_DW'(1);
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc      <= '0;
            ovf_flag <= 1'b0;
        end else if (hold_release) begin
            acc      <= '0;
            ovf_flag <= 1'b0;
        end else if (result_ok) begin
            acc <= acc_add[ACC_DW-1:0];
            if (acc_add[ACC_DW]) ovf_flag <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            beat_cnt   <= '0;
            trunc_flag <= 1'b0;
        end else if (hold_release) begin
            beat_cnt   <= '0;
            trunc_flag <= 1'b0;
        end else if (accept) begin
            if (beat_cnt < CNT_W'(MAX_BEATS)) beat_cnt <= beat_cnt + CNT_W'(1);
            if (forced && !i_last) trunc_flag <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (drain_done) sum_q <= acc;
            if (i_ta_vld && !result_ok) err_q <= 1'b1;
        end
    end

endmodule
